rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports clk and resetn.
REQ-002 Parameter RR_EN, default 1, SHALL select round-robin arbitration when 1 and fixed priority alu > lsu > mdu when 0.
REQ-003 Parameter CNT_W, default 16, SHALL set the width of the conflict counter.
REQ-004 clk  input  1  clock.
REQ-005 resetn  input  1  asynchronous active-low reset.
REQ-006 alu_wb_valid / lsu_wb_valid / mdu_wb_valid  input  1 each  writeback request from the ALU, load/store unit and mul/div unit.
REQ-007 alu_wb_ready / lsu_wb_ready / mdu_wb_ready  output  1 each  grant; the request is consumed when valid and ready are both 1 on a clk edge.
REQ-008 alu_wb_addr / lsu_wb_addr / mdu_wb_addr  input  5 each  destination register.
REQ-009 alu_wb_data / lsu_wb_data / mdu_wb_data  input  32 each  writeback data.
REQ-010 wb_stall  input  1  freezes the write port; no grants are issued while it is 1.
REQ-011 rf_we  output  1  register file write enable.
REQ-012 rf_waddr  output  5  register file write address.
REQ-013 rf_wdata  output  32  register file write data.
REQ-014 conflict_cnt  output  CNT_W  saturating count of cycles with two or more requests pending.

Function
REQ-015 In each cycle with wb_stall=0, the block SHALL grant at most one valid requester, and ready SHALL be combinational from the valid inputs, the pointer and wb_stall.
REQ-016 With RR_EN=1, a 2-bit pointer (reset 0: alu=0, lsu=1, mdu=2) SHALL name the highest-priority requester, and priority SHALL descend cyclically from it.
REQ-017 After a grant to requester i, the pointer SHALL become (i+1) mod 3; with no grant, the pointer SHALL hold.
REQ-018 With RR_EN=0, the pointer SHALL be ignored and priority SHALL be alu, then lsu, then mdu.
REQ-019 A granted request SHALL be registered, so that rf_we/rf_waddr/rf_wdata present it in the cycle after the handshake (latency 1) for exactly one cycle.
REQ-020 rf_we SHALL be 0 in any cycle following a cycle with no grant.
REQ-021 A granted request to register x0 SHALL be accepted and SHALL advance the pointer, but SHALL produce rf_we=0.
REQ-022 When wb_stall=1, all ready outputs SHALL be 0, the pointer SHALL hold, and rf_we SHALL be 0 in the following cycle.
REQ-023 The arbiter SHALL never grant a requester whose valid is 0, and SHALL rely on requesters holding valid, addr and data stable until accepted.
REQ-024 Writes SHALL reach the register file in grant order; of two requests to the same address in consecutive grants, the later one SHALL win.
REQ-025 conflict_cnt SHALL increment by 1 in each cycle where two or more valids are 1 (including under wb_stall), and SHALL saturate at all-ones without wrapping.
REQ-026 With RR_EN=1 and all three requesters continuously valid, each requester SHALL receive exactly one grant in every 3 consecutive cycles.

Reset
REQ-027 On resetn=0, the block SHALL asynchronously set rf_we=0, rf_waddr=0, rf_wdata=0, the pointer to 0 and conflict_cnt to 0.
REQ-028 While resetn=0, all ready outputs SHALL be 0.
REQ-029 A request in flight at reset assertion SHALL be discarded and SHALL NOT produce a write after reset release.
REQ-030 The first grant SHALL be possible in the first clk edge after resetn deasserts.

Structure
REQ-031 A shared package SHALL hold the requester index constants (ALU=0, LSU=1, MDU=2), the number of requesters (3) and the register address width (5).
REQ-032 The round-robin priority selection SHALL be one sub-module, rr_pick3, that takes valid[2:0] and the pointer and returns a one-hot grant.
REQ-033 Registers, output staging and the counter SHALL live in the top level.

Verification
REQ-034 After reset, a single alu request (addr 5, data 0xDEADBEEF) SHALL produce alu_wb_ready=1 in the same cycle and then rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF in the next cycle only.
REQ-035 With RR_EN=1, all three valid for 6 cycles from reset SHALL produce the grant order alu, lsu, mdu, alu, lsu, mdu, and conflict_cnt SHALL read 6 (5 on the final active cycle, per REQ-025 timing).
REQ-036 With RR_EN=0, alu and mdu both valid for 3 cycles SHALL give alu all 3 grants, after which dropping alu SHALL grant mdu on the next cycle.
REQ-037 An lsu request to x0 with data 0x1234 SHALL be handshaken, SHALL produce rf_we=0 on the following cycle, and the next grant SHALL start from mdu.
REQ-038 wb_stall=1 for 4 cycles with alu and lsu valid SHALL keep all ready outputs and rf_we at 0 and SHALL make conflict_cnt +4; on release, alu SHALL be granted first.
REQ-039 Asserting resetn=0 in the cycle of an mdu handshake SHALL force rf_we=0 immediately, and no write SHALL occur after release; with CNT_W=4 preloaded by 20 conflict cycles, conflict_cnt SHALL hold at 15.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter: requester indices,
// requester count and write-port widths.
package rf_wb_arbiter_pkg;

    localparam int NUM_REQ = 3;
    localparam int RADDR_W = 5;
    localparam int DATA_W  = 32;

    localparam logic [1:0] REQ_ALU = 2'd0;
    localparam logic [1:0] REQ_LSU = 2'd1;
    localparam logic [1:0] REQ_MDU = 2'd2;

    // Reduce a 0..5 sum back into the 0..2 requester index space.
    function automatic logic [1:0] wrap3(input logic [2:0] v);
        return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr_pick3.sv
// Three-way rotating-priority picker: the requester named by ptr has the highest
// priority and priority descends cyclically from it. Output grant is one-hot or zero.
module rr_pick3
    import rf_wb_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid,
    input  logic [1:0]         ptr,
    output logic [NUM_REQ-1:0] gnt
);

    logic       found;
    logic [1:0] idx;

    // An out-of-range pointer (3) wraps to 0, so it behaves like alu-first.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = wrap3({1'b0, ptr} + 3'(k));
            if (!found && valid[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: picks one of alu/lsu/mdu per cycle onto the single register
// file write port (latency 1), and counts cycles with competing requests.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int RR_EN = 1,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               resetn,

    input  logic               alu_wb_valid,
    output logic               alu_wb_ready,
    input  logic [RADDR_W-1:0] alu_wb_addr,
    input  logic [DATA_W-1:0]  alu_wb_data,

    input  logic               lsu_wb_valid,
    output logic               lsu_wb_ready,
    input  logic [RADDR_W-1:0] lsu_wb_addr,
    input  logic [DATA_W-1:0]  lsu_wb_data,

    input  logic               mdu_wb_valid,
    output logic               mdu_wb_ready,
    input  logic [RADDR_W-1:0] mdu_wb_addr,
    input  logic [DATA_W-1:0]  mdu_wb_data,

    input  logic               wb_stall,

    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]  rf_wdata,
    output logic [CNT_W-1:0]   conflict_cnt
);

    logic [NUM_REQ-1:0] req_vld;
    logic [NUM_REQ-1:0] pick;
    logic [NUM_REQ-1:0] gnt;
    logic [1:0]         ptr;
    logic [1:0]         pick_ptr;
    logic [1:0]         nxt_ptr;
    logic [RADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0]  gnt_data;
    logic               multi_req;

    assign req_vld  = {mdu_wb_valid, lsu_wb_valid, alu_wb_valid};

    // Fixed priority is the rotating picker with the pointer pinned at alu.
    assign pick_ptr = (RR_EN != 0) ? ptr : REQ_ALU;

    rr_pick3 u_pick (
        .valid (req_vld),
        .ptr   (pick_ptr),
        .gnt   (pick)
    );

    // Grants are masked while stalled and while reset is held.
    assign gnt          = (resetn && !wb_stall) ? pick : '0;
    assign alu_wb_ready = gnt[REQ_ALU];
    assign lsu_wb_ready = gnt[REQ_LSU];
    assign mdu_wb_ready = gnt[REQ_MDU];

    assign multi_req = (alu_wb_valid & lsu_wb_valid) |
                       (alu_wb_valid & mdu_wb_valid) |
                       (lsu_wb_valid & mdu_wb_valid);

    always_comb begin
        gnt_addr = '0;
        gnt_data = '0;
        nxt_ptr  = ptr;
        if (gnt[REQ_ALU]) begin
            gnt_addr = alu_wb_addr;
            gnt_data = alu_wb_data;
            nxt_ptr  = REQ_LSU;
        end else if (gnt[REQ_LSU]) begin
            gnt_addr = lsu_wb_addr;
            gnt_data = lsu_wb_data;
            nxt_ptr  = REQ_MDU;
        end else if (gnt[REQ_MDU]) begin
            gnt_addr = mdu_wb_addr;
            gnt_data = mdu_wb_data;
            nxt_ptr  = REQ_ALU;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            ptr          <= REQ_ALU;
            conflict_cnt <= '0;
        end else begin
            // x0 writes are consumed and rotate priority but never strobe the file.
            rf_we <= (|gnt) && (gnt_addr != '0);
            if (|gnt) begin
                rf_waddr <= gnt_addr;
                rf_wdata <= gnt_data;
                ptr      <= nxt_ptr;
            end
            if (multi_req && (conflict_cnt != {CNT_W{1'b1}}))
                conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: round-robin, fixed-priority and 4-bit
// counter instances share stimulus; expected writes go through a scoreboard queue.
module tb_rf_wb_arbiter;
    import rf_wb_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        alu_v = 1'b0, lsu_v = 1'b0, mdu_v = 1'b0, wb_stall = 1'b0;
    logic [4:0]  alu_a, lsu_a, mdu_a;
    logic [31:0] alu_d, lsu_d, mdu_d;

    logic [2:0]  rr_rdy, fp_rdy, c4_rdy;
    logic        rr_we, fp_we, c4_we;
    logic [4:0]  rr_addr, fp_addr, c4_addr;
    logic [31:0] rr_data, fp_data, c4_data;
    logic [15:0] rr_cnt, fp_cnt;
    logic [3:0]  c4_cnt;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic        sel;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    rf_wb_arbiter #(.RR_EN(1), .CNT_W(16)) dut_rr (
        .clk(clk), .resetn(resetn),
        .alu_wb_valid(alu_v), .alu_wb_ready(rr_rdy[0]), .alu_wb_addr(alu_a), .alu_wb_data(alu_d),
        .lsu_wb_valid(lsu_v), .lsu_wb_ready(rr_rdy[1]), .lsu_wb_addr(lsu_a), .lsu_wb_data(lsu_d),
        .mdu_wb_valid(mdu_v), .mdu_wb_ready(rr_rdy[2]), .mdu_wb_addr(mdu_a), .mdu_wb_data(mdu_d),
        .wb_stall(wb_stall), .rf_we(rr_we), .rf_waddr(rr_addr), .rf_wdata(rr_data),
        .conflict_cnt(rr_cnt)
    );

    rf_wb_arbiter #(.RR_EN(0), .CNT_W(16)) dut_fp (
        .clk(clk), .resetn(resetn),
        .alu_wb_valid(alu_v), .alu_wb_ready(fp_rdy[0]), .alu_wb_addr(alu_a), .alu_wb_data(alu_d),
        .lsu_wb_valid(lsu_v), .lsu_wb_ready(fp_rdy[1]), .lsu_wb_addr(lsu_a), .lsu_wb_data(lsu_d),
        .mdu_wb_valid(mdu_v), .mdu_wb_ready(fp_rdy[2]), .mdu_wb_addr(mdu_a), .mdu_wb_data(mdu_d),
        .wb_stall(wb_stall), .rf_we(fp_we), .rf_waddr(fp_addr), .rf_wdata(fp_data),
        .conflict_cnt(fp_cnt)
    );

    rf_wb_arbiter #(.RR_EN(1), .CNT_W(4)) dut_c4 (
        .clk(clk), .resetn(resetn),
        .alu_wb_valid(alu_v), .alu_wb_ready(c4_rdy[0]), .alu_wb_addr(alu_a), .alu_wb_data(alu_d),
        .lsu_wb_valid(lsu_v), .lsu_wb_ready(c4_rdy[1]), .lsu_wb_addr(lsu_a), .lsu_wb_data(lsu_d),
        .mdu_wb_valid(mdu_v), .mdu_wb_ready(c4_rdy[2]), .mdu_wb_addr(mdu_a), .mdu_wb_data(mdu_d),
        .wb_stall(wb_stall), .rf_we(c4_we), .rf_waddr(c4_addr), .rf_wdata(c4_data),
        .conflict_cnt(c4_cnt)
    );

    // Scoreboard: each entry is the write expected one clock after it was pushed.
    always @(negedge clk) begin : mon
        exp_t        e;
        logic        we;
        logic [4:0]  a;
        logic [31:0] d;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            we = e.sel ? fp_we   : rr_we;
            a  = e.sel ? fp_addr : rr_addr;
            d  = e.sel ? fp_data : rr_data;
            n_chk++;
            if (we !== e.we || (e.we && (a !== e.addr || d !== e.data))) begin
                n_fail++;
                $display("FAIL wb_write(dut%0d): got we=%0b addr=%0d data=%h, expected we=%0b addr=%0d data=%h",
                         e.sel, we, a, d, e.we, e.addr, e.data);
            end
        end
    end

    // g: 0=alu, 1=lsu, 2=mdu, anything else = no grant
    task automatic push(input logic sel, input int g);
        exp_t e;
        e.sel = sel; e.we = 1'b0; e.addr = '0; e.data = '0;
        case (g)
            0: begin e.addr = alu_a; e.data = alu_d; e.we = (alu_a != 0); end
            1: begin e.addr = lsu_a; e.data = lsu_d; e.we = (lsu_a != 0); end
            2: begin e.addr = mdu_a; e.data = mdu_d; e.we = (mdu_a != 0); end
            default: ;
        endcase
        exp_q.push_back(e);
    endtask

    task automatic set_defaults();
        alu_a = 5'd5; alu_d = 32'hDEAD_BEEF;
        lsu_a = 5'd7; lsu_d = 32'hA5A5_0001;
        mdu_a = 5'd9; mdu_d = 32'h0000_C0DE;
    endtask

    // Called at a negedge; returns at a negedge just after release.
    task automatic apply_reset();
        resetn = 1'b0;
        alu_v = 1'b0; lsu_v = 1'b0; mdu_v = 1'b0; wb_stall = 1'b0;
        set_defaults();
        repeat (2) @(negedge clk);
        exp_q.delete();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        set_defaults();
        @(negedge clk);
        resetn = 1'b0;
        alu_v = 1'b1; lsu_v = 1'b1; mdu_v = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if (rr_rdy !== 3'b000 || fp_rdy !== 3'b000 || c4_rdy !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ready: got rr=%b fp=%b c4=%b, expected 000", rr_rdy, fp_rdy, c4_rdy);
        end
        n_chk++;
        if (rr_we !== 1'b0 || rr_addr !== 5'd0 || rr_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_rf: got we=%0b addr=%0d data=%h, expected 0/0/0", rr_we, rr_addr, rr_data);
        end
        n_chk++;
        if (rr_cnt !== 16'd0 || c4_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got rr=%0d c4=%0d, expected 0", rr_cnt, c4_cnt);
        end
        apply_reset();
    endtask

    // Single alu write granted on the very first edge after release.
    task automatic test_single();
        apply_reset();
        alu_v = 1'b1;
        #1;
        n_chk++;
        if (rr_rdy !== 3'b001) begin
            n_fail++;
            $display("FAIL single_ready: got %b, expected 001", rr_rdy);
        end
        push(1'b0, 0);
        @(negedge clk);
        alu_v = 1'b0;
        #1;
        n_chk++;
        if (rr_rdy !== 3'b000) begin
            n_fail++;
            $display("FAIL single_idle_ready: got %b, expected 000", rr_rdy);
        end
        push(1'b0, 3);
        @(negedge clk);
    endtask

    task automatic test_rr_all();
        logic [2:0] exp_g;
        apply_reset();
        alu_v = 1'b1; lsu_v = 1'b1; mdu_v = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            exp_g = 3'b001 << (k % 3);
            n_chk++;
            if (rr_rdy !== exp_g) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: got %b, expected %b", k, rr_rdy, exp_g);
            end
            n_chk++;
            if (rr_cnt !== 16'(k)) begin
                n_fail++;
                $display("FAIL rr_cnt[%0d]: got %0d, expected %0d", k, rr_cnt, k);
            end
            push(1'b0, k % 3);
            @(negedge clk);
        end
        alu_v = 1'b0; lsu_v = 1'b0; mdu_v = 1'b0;
        #1;
        n_chk++;
        if (rr_cnt !== 16'd6) begin
            n_fail++;
            $display("FAIL rr_cnt_final: got %0d, expected 6", rr_cnt);
        end
        push(1'b0, 3);
        @(negedge clk);
    endtask

    task automatic test_fixed();
        apply_reset();
        alu_v = 1'b1; mdu_v = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_chk++;
            if (fp_rdy !== 3'b001) begin
                n_fail++;
                $display("FAIL fixed_alu[%0d]: got %b, expected 001", k, fp_rdy);
            end
            push(1'b1, 0);
            @(negedge clk);
        end
        alu_v = 1'b0;
        #1;
        n_chk++;
        if (fp_rdy !== 3'b100) begin
            n_fail++;
            $display("FAIL fixed_mdu: got %b, expected 100", fp_rdy);
        end
        push(1'b1, 2);
        @(negedge clk);
        mdu_v = 1'b0;
        #1;
        push(1'b1, 3);
        @(negedge clk);
    endtask

    task automatic test_x0();
        apply_reset();
        lsu_a = 5'd0; lsu_d = 32'h0000_1234; lsu_v = 1'b1;
        #1;
        n_chk++;
        if (rr_rdy !== 3'b010) begin
            n_fail++;
            $display("FAIL x0_ready: got %b, expected 010", rr_rdy);
        end
        push(1'b0, 1);
        @(negedge clk);
        set_defaults();
        alu_v = 1'b1; lsu_v = 1'b1; mdu_v = 1'b1;
        #1;
        n_chk++;
        if (rr_rdy !== 3'b100) begin
            n_fail++;
            $display("FAIL x0_next_mdu: got %b, expected 100", rr_rdy);
        end
        push(1'b0, 2);
        @(negedge clk);
        #1;
        n_chk++;
        if (rr_rdy !== 3'b001) begin
            n_fail++;
            $display("FAIL x0_then_alu: got %b, expected 001", rr_rdy);
        end
        push(1'b0, 0);
        @(negedge clk);
        alu_v = 1'b0; lsu_v = 1'b0; mdu_v = 1'b0;
        #1;
        push(1'b0, 3);
        @(negedge clk);
    endtask

    task automatic test_stall();
        apply_reset();
        wb_stall = 1'b1;
        alu_v = 1'b1; lsu_v = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_chk++;
            if (rr_rdy !== 3'b000 || fp_rdy !== 3'b000) begin
                n_fail++;
                $display("FAIL stall_ready[%0d]: got rr=%b fp=%b, expected 000", k, rr_rdy, fp_rdy);
            end
            push(1'b0, 3);
            @(negedge clk);
        end
        n_chk++;
        if (rr_cnt !== 16'd4) begin
            n_fail++;
            $display("FAIL stall_cnt: got %0d, expected 4", rr_cnt);
        end
        wb_stall = 1'b0;
        #1;
        n_chk++;
        if (rr_rdy !== 3'b001) begin
            n_fail++;
            $display("FAIL stall_release_alu: got %b, expected 001", rr_rdy);
        end
        push(1'b0, 0);
        @(negedge clk);
        alu_v = 1'b0;
        #1;
        n_chk++;
        if (rr_rdy !== 3'b010) begin
            n_fail++;
            $display("FAIL stall_then_lsu: got %b, expected 010", rr_rdy);
        end
        push(1'b0, 1);
        @(negedge clk);
        lsu_v = 1'b0;
        #1;
        push(1'b0, 3);
        @(negedge clk);
    endtask

    // Same destination in consecutive grants: the later lsu data must land last.
    task automatic test_back_to_back();
        apply_reset();
        alu_a = 5'd3; alu_d = 32'h1111_1111;
        lsu_a = 5'd3; lsu_d = 32'h2222_2222;
        alu_v = 1'b1; lsu_v = 1'b1;
        #1;
        push(1'b0, 0);
        @(negedge clk);
        alu_v = 1'b0;
        #1;
        push(1'b0, 1);
        @(negedge clk);
        lsu_v = 1'b0;
        #1;
        push(1'b0, 3);
        @(negedge clk);
        n_chk++;
        if (rr_addr !== 5'd3 || rr_data !== 32'h2222_2222) begin
            n_fail++;
            $display("FAIL b2b_last_wins: got addr=%0d data=%h, expected 3/22222222", rr_addr, rr_data);
        end
        set_defaults();
    endtask

    task automatic test_reset_inflight();
        apply_reset();
        alu_v = 1'b1; lsu_v = 1'b1;
        repeat (20) @(negedge clk);
        n_chk++;
        if (c4_cnt !== 4'd15) begin
            n_fail++;
            $display("FAIL cnt_saturate: got %0d, expected 15", c4_cnt);
        end
        n_chk++;
        if (rr_cnt !== 16'd20) begin
            n_fail++;
            $display("FAIL cnt_20: got %0d, expected 20", rr_cnt);
        end
        alu_v = 1'b0; lsu_v = 1'b0;
        @(negedge clk);
        mdu_v = 1'b1;
        #1;
        n_chk++;
        if (rr_rdy !== 3'b100) begin
            n_fail++;
            $display("FAIL inflight_ready: got %b, expected 100", rr_rdy);
        end
        #2;
        resetn = 1'b0;
        #1;
        n_chk++;
        if (rr_we !== 1'b0 || rr_rdy !== 3'b000 || rr_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL inflight_reset: got we=%0b rdy=%b cnt=%0d, expected 0/000/0", rr_we, rr_rdy, rr_cnt);
        end
        mdu_v = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_chk++;
            if (rr_we !== 1'b0) begin
                n_fail++;
                $display("FAIL inflight_no_write[%0d]: got we=%0b, expected 0", k, rr_we);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_rr_all();
        test_fixed();
        test_x0();
        test_stall();
        test_back_to_back();
        test_reset_inflight();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
